// File: rtl/switch_fabric.sv
// switch_fabric: drains three input-queue RAMs and routes each packet to one of three
// output ports, with a round-robin arbiter per output and a saturating busy-cycle counter.
module switch_fabric (
    input  logic        clk,
    input  logic        reset,
    input  logic        enable,
    input  logic [11:0] input_ram_wr_add1,
    input  logic [11:0] input_ram_wr_add2,
    input  logic [11:0] input_ram_wr_add3,
    input  logic [31:0] input_q1,
    input  logic [31:0] input_q2,
    input  logic [31:0] input_q3,
    output logic [11:0] input_ram_rd_add1,
    output logic [11:0] input_ram_rd_add2,
    output logic [11:0] input_ram_rd_add3,
    output logic [31:0] output1,
    output logic [31:0] output2,
    output logic [31:0] output3,
    output logic        out_ram_wr1,
    output logic        out_ram_wr2,
    output logic        out_ram_wr3,
    output logic [31:0] total_time
);
    typedef enum logic [2:0] {IDLE, HDR, REQ, FWD, DROP} state_t;
    state_t           st_q [3];
    state_t           st_d [3];
    logic [2:0][11:0] wr_add, rd_q, rd_d;
    logic [2:0][31:0] q, hdr_q, hdr_d, out_q, out_d, word;
    logic [2:0][7:0]  rem_q, rem_d;
    logic [2:0][1:0]  prio_q, prio_d;
    logic [2:0][2:0]  req, win;
    logic [2:0]       pend_q, pend_d, first_q, first_d, wr_q, wr_d;
    logic [2:0]       busy, strobe, empty, granted;
    logic [31:0]      time_q, time_d;

    assign wr_add = {input_ram_wr_add3, input_ram_wr_add2, input_ram_wr_add1};
    assign q = {input_q3, input_q2, input_q1};

    // An output is owned while some input sits in FWD for it; the FWD state is the registered grant.
    always_comb begin
        logic [1:0] j;
        prio_d = prio_q;
        for (int o = 0; o < 3; o++) begin
            busy[o] = 1'b0;
            win[o] = '0;
            for (int i = 0; i < 3; i++) begin
                req[o][i] = st_q[i] == REQ && hdr_q[i][1:0] == 2'(o);
                busy[o] = busy[o] | (st_q[i] == FWD && hdr_q[i][1:0] == 2'(o));
            end
            for (int k = 2; k >= 0; k--) begin
                j = 2'((int'(prio_q[o]) + k) % 3);
                if (!busy[o] && req[o][j]) begin
                    win[o] = 3'b001 << j;
                    prio_d[o] = j == 2'd2 ? 2'd0 : j + 2'd1;
                end
            end
        end
    end

    // pend marks a payload read issued last cycle, whose word is on input_q now.
    always_comb begin
        for (int i = 0; i < 3; i++) begin
            st_d[i] = st_q[i];
            rd_d[i] = rd_q[i];
            hdr_d[i] = hdr_q[i];
            rem_d[i] = rem_q[i];
            pend_d[i] = 1'b0;
            first_d[i] = 1'b0;
            empty[i] = rd_q[i] == wr_add[i];
            granted[i] = win[0][i] | win[1][i] | win[2][i];
            strobe[i] = st_q[i] == FWD && (first_q[i] || pend_q[i]);
            word[i] = first_q[i] ? hdr_q[i] : q[i];
            case (st_q[i])
                IDLE: if (enable && !empty[i]) begin
                    rd_d[i] = rd_q[i] + 12'd1;
                    st_d[i] = HDR;
                end
                HDR: begin
                    hdr_d[i] = q[i];
                    rem_d[i] = q[i][11:4];
                    st_d[i] = q[i][1:0] == 2'd3 ? DROP : REQ;
                end
                REQ: if (granted[i]) begin
                    st_d[i] = FWD;
                    first_d[i] = 1'b1;
                end
                FWD, DROP: begin
                    if (rem_q[i] != 8'd0 && !empty[i]) begin
                        rd_d[i] = rd_q[i] + 12'd1;
                        rem_d[i] = rem_q[i] - 8'd1;
                        pend_d[i] = 1'b1;
                    end
                    if (rem_q[i] == 8'd0 && (st_q[i] == DROP || strobe[i])) st_d[i] = IDLE;
                end
                default: st_d[i] = IDLE;
            endcase
        end
    end

    always_comb begin
        out_d = out_q;
        wr_d = '0;
        for (int o = 0; o < 3; o++) begin
            for (int i = 0; i < 3; i++) begin
                if (strobe[i] && hdr_q[i][1:0] == 2'(o)) begin
                    out_d[o] = word[i];
                    wr_d[o] = 1'b1;
                end
            end
        end
        time_d = ((st_q[0] != IDLE || st_q[1] != IDLE || st_q[2] != IDLE) && time_q != '1) ? time_q + 32'd1 : time_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            st_q <= '{IDLE, IDLE, IDLE};
            rd_q <= '0;
            hdr_q <= '0;
            rem_q <= '0;
            pend_q <= '0;
            first_q <= '0;
            prio_q <= '0;
            out_q <= '0;
            wr_q <= '0;
            time_q <= '0;
        end else begin
            st_q <= st_d;
            rd_q <= rd_d;
            hdr_q <= hdr_d;
            rem_q <= rem_d;
            pend_q <= pend_d;
            first_q <= first_d;
            prio_q <= prio_d;
            out_q <= out_d;
            wr_q <= wr_d;
            time_q <= time_d;
        end
    end

    assign input_ram_rd_add1 = rd_q[0];
    assign input_ram_rd_add2 = rd_q[1];
    assign input_ram_rd_add3 = rd_q[2];
    assign output1 = out_q[0];
    assign output2 = out_q[1];
    assign output3 = out_q[2];
    assign out_ram_wr1 = wr_q[0];
    assign out_ram_wr2 = wr_q[1];
    assign out_ram_wr3 = wr_q[2];
    assign total_time = time_q;
endmodule

// File: tb/tb_switch_fabric.sv
// tb_switch_fabric: queue-RAM model plus per-output scoreboard; each task drives one scenario.
module tb_switch_fabric;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        enable = 1'b0;
    logic [11:0] wa [3];
    logic [11:0] ra [3];
    logic [11:0] wp [3];
    logic [31:0] iq [3];
    logic [31:0] ow [3];
    logic [2:0]  ws;
    logic [31:0] total_time;
    logic [31:0] mem [3][4096];
    logic [31:0] expq [3][$];
    int vectors = 0;
    int miscompares = 0;
    int tag = 1;

    always #5 clk = ~clk;

    switch_fabric dut (
        .clk(clk), .reset(reset), .enable(enable),
        .input_ram_wr_add1(wa[0]), .input_ram_wr_add2(wa[1]), .input_ram_wr_add3(wa[2]),
        .input_q1(iq[0]), .input_q2(iq[1]), .input_q3(iq[2]),
        .input_ram_rd_add1(ra[0]), .input_ram_rd_add2(ra[1]), .input_ram_rd_add3(ra[2]),
        .output1(ow[0]), .output2(ow[1]), .output3(ow[2]),
        .out_ram_wr1(ws[0]), .out_ram_wr2(ws[1]), .out_ram_wr3(ws[2]),
        .total_time(total_time)
    );

    always @(posedge clk) for (int i = 0; i < 3; i++) iq[i] <= mem[i][ra[i]];

    always @(negedge clk) begin
        logic [31:0] e;
        for (int o = 0; o < 3; o++) begin
            if (ws[o] === 1'b1) begin
                vectors++;
                if (expq[o].size() == 0) begin
                    miscompares++;
                    $display("FAIL out%0d_unexpected got=%h required=no strobe", o + 1, ow[o]);
                end else begin
                    e = expq[o].pop_front();
                    if (ow[o] !== e) begin
                        miscompares++;
                        $display("FAIL out%0d_data got=%h required=%h", o + 1, ow[o], e);
                    end
                end
            end
        end
    end

    task automatic push_pkt(input int i, input int dest, input int len);
        logic [31:0] w;
        w = {tag[15:0], 4'h0, len[7:0], 2'b00, dest[1:0]};
        for (int k = 0; k <= len; k++) begin
            if (k > 0) w = {tag[15:0], 16'(k)};
            mem[i][wp[i]] = w;
            if (dest != 3) expq[dest].push_back(w);
            wp[i] = wp[i] + 12'd1;
        end
        tag++;
    endtask

    task automatic publish();
        for (int i = 0; i < 3; i++) wa[i] = wp[i];
    endtask

    task automatic wait_idle(input int budget, input string name);
        int n = 0;
        while (n < budget && !(ra[0] == wp[0] && ra[1] == wp[1] && ra[2] == wp[2] &&
               expq[0].size() == 0 && expq[1].size() == 0 && expq[2].size() == 0)) begin
            @(negedge clk);
            n++;
        end
        repeat (4) @(negedge clk);
        vectors++;
        if (n >= budget) begin
            miscompares++;
            $display("FAIL %s_timeout cycles=%0d required<%0d", name, n, budget);
        end
    endtask

    task automatic check_cleared(input string name);
        for (int i = 0; i < 3; i++) begin
            vectors++;
            if (ra[i] !== 12'd0 || ow[i] !== 32'd0 || ws[i] !== 1'b0) begin
                miscompares++;
                $display("FAIL %s_port%0d got rd=%h out=%h wr=%b required 0/0/0", name, i + 1, ra[i], ow[i], ws[i]);
            end
        end
        vectors++;
        if (total_time !== 32'd0) begin
            miscompares++;
            $display("FAIL %s_total_time got=%0d required=0", name, total_time);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        enable = 1'b0;
        for (int i = 0; i < 3; i++) begin
            wa[i] = '0;
            wp[i] = '0;
        end
        repeat (3) @(negedge clk);
        check_cleared("reset");
        reset = 1'b0;
        enable = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_single();
        push_pkt(0, 0, 2);
        publish();
        for (int c = 1; c <= 9; c++) begin
            @(negedge clk);
            vectors++;
            if (ws[0] !== 1'(c >= 4 && c <= 6)) begin
                miscompares++;
                $display("FAIL single_strobe_cycle%0d got=%b required=%b", c, ws[0], c >= 4 && c <= 6);
            end
        end
        vectors++;
        if (ra[0] !== 12'd3) begin
            miscompares++;
            $display("FAIL single_rd_add got=%0d required=3", ra[0]);
        end
        vectors++;
        if (total_time !== 32'd5) begin
            miscompares++;
            $display("FAIL single_total_time got=%0d required=5", total_time);
        end
    endtask

    task automatic test_contention();
        push_pkt(0, 1, 1);
        push_pkt(1, 1, 1);
        push_pkt(2, 1, 1);
        publish();
        wait_idle(200, "contention");
    endtask

    task automatic test_parallel();
        int first [3];
        int cnt [3];
        for (int o = 0; o < 3; o++) begin
            first[o] = 0;
            cnt[o] = 0;
        end
        push_pkt(0, 2, 4);
        push_pkt(1, 0, 4);
        push_pkt(2, 1, 4);
        publish();
        for (int c = 1; c <= 15; c++) begin
            @(negedge clk);
            for (int o = 0; o < 3; o++) begin
                if (ws[o] === 1'b1) begin
                    cnt[o]++;
                    if (first[o] == 0) first[o] = c;
                end
            end
        end
        for (int o = 0; o < 3; o++) begin
            vectors++;
            if (first[o] != 4 || cnt[o] != 5) begin
                miscompares++;
                $display("FAIL parallel_out%0d got first=%0d count=%0d required first=4 count=5", o + 1, first[o], cnt[o]);
            end
        end
        wait_idle(100, "parallel");
    endtask

    task automatic test_drop();
        logic [11:0] base;
        int n = 0;
        base = wp[0];
        push_pkt(0, 3, 5);
        publish();
        for (int c = 1; c <= 20; c++) begin
            @(negedge clk);
            if (ws !== 3'b000) n++;
        end
        vectors++;
        if (n != 0) begin
            miscompares++;
            $display("FAIL drop_strobes got=%0d required=0", n);
        end
        vectors++;
        if (ra[0] !== base + 12'd6) begin
            miscompares++;
            $display("FAIL drop_rd_add got=%0d required=%0d", ra[0], base + 12'd6);
        end
    endtask

    task automatic test_stall();
        logic [11:0] base;
        int s [$];
        base = wp[1];
        push_pkt(1, 0, 3);
        wa[1] = base + 12'd1;
        for (int c = 1; c <= 20; c++) begin
            @(negedge clk);
            if (ws[0] === 1'b1) s.push_back(c);
            if (c == 3 || c == 6 || c == 9) wa[1] = wa[1] + 12'd1;
        end
        vectors++;
        if (s.size() != 4) begin
            miscompares++;
            $display("FAIL stall_count got=%0d required=4", s.size());
        end else begin
            vectors++;
            if (s[0] != 4) begin
                miscompares++;
                $display("FAIL stall_header_cycle got=%0d required=4", s[0]);
            end
            for (int k = 2; k < 4; k++) begin
                vectors++;
                if (s[k] - s[k-1] != 3) begin
                    miscompares++;
                    $display("FAIL stall_gap%0d got=%0d required=3", k, s[k] - s[k-1]);
                end
            end
        end
        vectors++;
        if (ra[1] !== base + 12'd4) begin
            miscompares++;
            $display("FAIL stall_rd_add got=%0d required=%0d", ra[1], base + 12'd4);
        end
    endtask

    task automatic test_reset_mid();
        push_pkt(0, 0, 20);
        publish();
        repeat (8) @(negedge clk);
        reset = 1'b1;
        for (int i = 0; i < 3; i++) wa[i] = '0;
        @(negedge clk);
        check_cleared("reset_mid");
        for (int o = 0; o < 3; o++) expq[o].delete();
        for (int i = 0; i < 3; i++) wp[i] = '0;
        reset = 1'b0;
        repeat (6) @(negedge clk);
        vectors++;
        if (ra[0] !== 12'd0 || ws !== 3'b000) begin
            miscompares++;
            $display("FAIL reset_mid_after got rd=%0d wr=%b required rd=0 wr=000", ra[0], ws);
        end
    endtask

    task automatic test_wrap();
        for (int k = 0; k < 15; k++) push_pkt(0, 3, 255);
        push_pkt(0, 3, 253);
        publish();
        wait_idle(5000, "wrap_fill");
        vectors++;
        if (ra[0] !== 12'd4094) begin
            miscompares++;
            $display("FAIL wrap_fill_rd_add got=%0d required=4094", ra[0]);
        end
        push_pkt(0, 0, 2);
        publish();
        wait_idle(100, "wrap");
        vectors++;
        if (ra[0] !== 12'd1) begin
            miscompares++;
            $display("FAIL wrap_rd_add got=%0d required=1", ra[0]);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_contention();
        test_parallel();
        test_drop();
        test_stall();
        wait_idle(100, "stall_drain");
        test_reset_mid();
        test_wrap();
        for (int o = 0; o < 3; o++) begin
            vectors++;
            if (expq[o].size() != 0) begin
                miscompares++;
                $display("FAIL out%0d_leftover got=%0d words pending required=0", o + 1, expq[o].size());
            end
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog got=timeout required=completion");
        $fatal(1, "watchdog expired");
    end
endmodule
